saturating_accumulator: RTL and testbench
=========================================

SATURATING_ACCUMULATOR -- requirements
Module: saturating_accumulator

Interface
REQ-001 The block SHALL have parameter size, default 22, giving the signed two's-complement word width of the product, accumulator and result.
REQ-002 The block SHALL have parameter N_TERMS, default 5, giving the number of products summed per output sample (range 1..255).
REQ-003 Port clk SHALL be an input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit, asynchronous active-low reset.
REQ-005 Port start SHALL be an input, 1 bit, a request to begin a new sum.
REQ-006 Port prod SHALL be a signed input, size bits, the saturated product from the upstream multiplier.
REQ-007 Port prod_valid SHALL be an input, 1 bit, marking prod as valid this cycle.
REQ-008 Port prod_ready SHALL be an output, 1 bit, meaning the block accepts prod this cycle.
REQ-009 Port result SHALL be a signed output, size bits, the last completed sum.
REQ-010 Port result_valid SHALL be an output, 1 bit, a one-cycle pulse when result updates.
REQ-011 Port busy SHALL be an output, 1 bit, high while a sum is in progress.
REQ-012 Port sat SHALL be an output, 1 bit, high with result_valid if any add in that sum clamped.

Function
REQ-013 The FSM SHALL have states IDLE, ACCUM and DONE.
REQ-014 In IDLE: prod_ready=0, busy=0; start=1 clears acc to 0, cnt to 0 and the sticky sat flag, then goes to ACCUM next cycle.
REQ-015 In ACCUM: prod_ready=1, busy=1; a product is accepted only when prod_valid and prod_ready are both 1.
REQ-016 On acceptance, acc SHALL become sat_add(acc, prod) and cnt SHALL increment.
REQ-017 The acceptance with cnt==N_TERMS-1 SHALL move the FSM to DONE; prod_ready SHALL be 0 from the next cycle on.
REQ-018 In DONE (exactly one cycle): result<=acc, sat<=sticky flag, result_valid=1, busy=1; then return to IDLE.
REQ-019 Latency SHALL be 2 cycles from the final accepted product to the result_valid pulse.
REQ-020 start SHALL be ignored in ACCUM and DONE.
REQ-021 prod_valid SHALL be ignored in IDLE and DONE; gaps in prod_valid in ACCUM SHALL stall without changing acc or cnt.
REQ-022 sat_add SHALL clamp overflow: if both operands are non-negative and the raw sum is negative, the result is 2^(size-1)-1; if both are negative and the raw sum is non-negative, the result is -2^(size-1); otherwise the result is the raw sum. Each clamp sets the sticky flag.
REQ-023 Accumulation SHALL continue from the clamped value, so later terms can pull the sum back in range.
REQ-024 result and sat SHALL hold their values between result_valid pulses.

Reset
REQ-025 rst_n low SHALL asynchronously force: FSM=IDLE, acc=0, cnt=0, sticky=0, result=0, result_valid=0, sat=0, busy=0, prod_ready=0.
REQ-026 A reset during ACCUM SHALL discard the partial sum; no result_valid SHALL follow.
REQ-027 Release of rst_n SHALL take effect on the next clk edge; start sampled on that edge is honoured.

Structure
REQ-028 A shared package SHALL hold the default SIZE, the MAX/MIN saturation constants derived from size, and the FSM state encoding.
REQ-029 The saturating adder SHALL be a separate combinational sub-module, sat_adder, parameterised by size, with a signed sum output and an overflow output.
REQ-030 The counter width SHALL be the minimum needed to hold N_TERMS-1.

Verification (size=22, N_TERMS=5 unless stated)
REQ-031 start, then products 1,2,3,4,5 back-to-back -> result=15, sat=0, result_valid 2 cycles after the 5th accept.
REQ-032 Five products of 2097151 -> result=2097151, sat=1; five of -2097152 -> result=-2097152, sat=1.
REQ-033 Products 2097151, 10, -20, 0, 0 -> clamp then recover: result=2097131, sat=1.
REQ-034 Same values as REQ-031 with prod_valid low on alternate cycles -> result=15; acc is unchanged during the gaps.
REQ-035 Reset asserted after 3 accepts, then start and five products of 1 -> no pulse before reset; result=5 after.
REQ-036 start pulsed during ACCUM, and prod_valid driven in IDLE -> both ignored; cnt and acc are unchanged.

Source files
------------

// File: rtl/saturating_accumulator_pkg.sv
// Shared definitions for the saturating accumulator slice: default word
// width, saturation limits for that width, FSM state encoding and a helper
// that sizes the term counter.
package saturating_accumulator_pkg;

    // Default signed word width of product, accumulator and result
    localparam int SIZE = 22;

    // Saturation limits for the default width
    localparam logic signed [SIZE-1:0] SAT_MAX = {1'b0, {(SIZE-1){1'b1}}};
    localparam logic signed [SIZE-1:0] SAT_MIN = {1'b1, {(SIZE-1){1'b0}}};

    // Accumulator control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Smallest counter width able to hold n_terms-1 (never below one bit)
    function automatic int cnt_width(input int n_terms);
        int w;
        w = 1;
        if (n_terms > 2) begin
            w = $clog2(n_terms);
        end
        return w;
    endfunction

endpackage

// File: rtl/saturating_accumulator_sat_adder.sv
// Combinational two's-complement adder that clamps to the most positive or
// most negative representable value instead of wrapping around.
module sat_adder
    import saturating_accumulator_pkg::*;
#(
    parameter int size = SIZE
) (
    input  logic signed [size-1:0] i_a,
    input  logic signed [size-1:0] i_b,
    output logic signed [size-1:0] o_sum,
    output logic                   o_overflow
);

    localparam logic signed [size-1:0] MAX_VAL = {1'b0, {(size-1){1'b1}}};
    localparam logic signed [size-1:0] MIN_VAL = {1'b1, {(size-1){1'b0}}};

    logic signed [size-1:0] w_raw;
    logic                   w_pos_ovf;
    logic                   w_neg_ovf;

    // Wrapped sum; overflow is detected from the operand and result signs
    assign w_raw     = i_a + i_b;
    assign w_pos_ovf = ~i_a[size-1] & ~i_b[size-1] &  w_raw[size-1];
    assign w_neg_ovf =  i_a[size-1] &  i_b[size-1] & ~w_raw[size-1];

    // Pick the clamp value when the wrapped sum has the wrong sign
    always_comb begin
        o_sum      = w_raw;
        o_overflow = 1'b0;
        if (w_pos_ovf) begin
            o_sum      = MAX_VAL;
            o_overflow = 1'b1;
        end else if (w_neg_ovf) begin
            o_sum      = MIN_VAL;
            o_overflow = 1'b1;
        end
    end

endmodule

// File: rtl/saturating_accumulator.sv
// Sums N_TERMS saturated products per output sample. A start request in
// IDLE opens a new sum, products are taken through a valid/ready handshake
// while accumulating, and the finished sum is published one cycle after the
// last term together with a sticky flag telling whether any add clamped.
module saturating_accumulator
    import saturating_accumulator_pkg::*;
#(
    parameter int size    = SIZE,
    parameter int N_TERMS = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic signed [size-1:0] prod,
    input  logic                   prod_valid,
    output logic                   prod_ready,
    output logic signed [size-1:0] result,
    output logic                   result_valid,
    output logic                   busy,
    output logic                   sat
);

    localparam int              CNT_W    = cnt_width(N_TERMS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    state_t r_state;
    state_t w_next_state;

    logic signed [size-1:0] r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_sticky;
    logic signed [size-1:0] r_result;
    logic                   r_sat;
    logic                   r_result_valid;

    logic                   w_prod_ready;
    logic                   w_busy;
    logic                   w_accept;
    logic                   w_clear;
    logic                   w_last;
    logic signed [size-1:0] w_sum;
    logic                   w_ovf;

    sat_adder #(
        .size (size)
    ) u_sat_adder (
        .i_a        (r_acc),
        .i_b        (prod),
        .o_sum      (w_sum),
        .o_overflow (w_ovf)
    );

    assign w_accept = prod_valid & w_prod_ready;
    assign w_clear  = (r_state == IDLE) & start;
    assign w_last   = w_accept & (r_cnt == LAST_CNT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake/status outputs for the current state
    always_comb begin
        w_next_state = r_state;
        w_prod_ready = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = ACCUM;
                end
            end
            ACCUM: begin
                w_prod_ready = 1'b1;
                w_busy       = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_busy       = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Running sum, term count and sticky clamp flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else if (w_clear) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_ovf) begin
                r_sticky <= 1'b1;
            end
        end
    end

    // Publish the finished sum; result and sat hold until the next sum ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result       <= '0;
            r_sat          <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= (r_state == DONE);
            if (r_state == DONE) begin
                r_result <= r_acc;
                r_sat    <= r_sticky;
            end
        end
    end

    assign prod_ready   = w_prod_ready;
    assign busy         = w_busy;
    assign result       = r_result;
    assign sat          = r_sat;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_saturating_accumulator.sv
// Self-checking bench for saturating_accumulator: a transaction-level model
// tracks what every output must be each cycle, and directed sums pin the
// model against hand-computed results.
module tb_saturating_accumulator;

    localparam int     SIZE_P = 22;
    localparam int     N_P    = 5;
    localparam longint MAXV   = 2097151;
    localparam longint MINV   = -2097152;

    logic                     clk        = 1'b0;
    logic                     rst_n      = 1'b0;
    logic                     start      = 1'b0;
    logic signed [SIZE_P-1:0] prod       = '0;
    logic                     prod_valid = 1'b0;
    logic                     prod_ready;
    logic signed [SIZE_P-1:0] result;
    logic                     result_valid;
    logic                     busy;
    logic                     sat;

    saturating_accumulator #(
        .size    (SIZE_P),
        .N_TERMS (N_P)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .prod         (prod),
        .prod_valid   (prod_valid),
        .prod_ready   (prod_ready),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .sat          (sat)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Single comparison point: counts and reports every check
    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 = waiting for start, 1 = collecting terms,
    // 2 = publishing. Sum is kept in wide arithmetic and clamped to range.
    int     m_phase           = 0;
    longint m_acc             = 0;
    int     m_terms           = 0;
    bit     m_sticky          = 1'b0;
    longint m_result          = 0;
    bit     m_sat             = 1'b0;
    bit     m_rv              = 1'b0;
    int     cyc               = 0;
    int     m_last_accept_cyc = 0;

    // Model update on each clock edge; reset clears everything at once
    always @(posedge clk or negedge rst_n) begin
        longint s;
        if (!rst_n) begin
            m_phase  = 0;
            m_acc    = 0;
            m_terms  = 0;
            m_sticky = 1'b0;
            m_result = 0;
            m_sat    = 1'b0;
            m_rv     = 1'b0;
        end else begin
            m_rv = 1'b0;
            if (m_phase == 0) begin
                if (start) begin
                    m_acc    = 0;
                    m_terms  = 0;
                    m_sticky = 1'b0;
                    m_phase  = 1;
                end
            end else if (m_phase == 1) begin
                if (prod_valid) begin
                    s = m_acc + longint'(prod);
                    if (s > MAXV) begin
                        s        = MAXV;
                        m_sticky = 1'b1;
                    end else if (s < MINV) begin
                        s        = MINV;
                        m_sticky = 1'b1;
                    end
                    m_acc   = s;
                    m_terms = m_terms + 1;
                    if (m_terms == N_P) begin
                        m_phase           = 2;
                        m_last_accept_cyc = cyc;
                    end
                end
            end else begin
                m_result = m_acc;
                m_sat    = m_sticky;
                m_rv     = 1'b1;
                m_phase  = 0;
            end
            cyc++;
        end
    end

    bit     checking    = 1'b0;
    int     rv_count    = 0;
    int     rv_cyc      = 0;
    longint last_result = 0;
    bit     last_sat    = 1'b0;

    // Compare every output against the model on the falling edge
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("result_valid", longint'(result_valid), longint'(m_rv));
            checkOutput("result", longint'(result), m_result);
            checkOutput("sat", longint'(sat), longint'(m_sat));
            checkOutput("busy", longint'(busy), longint'(m_phase != 0));
            checkOutput("prod_ready", longint'(prod_ready), longint'(m_phase == 1));
            if (result_valid) begin
                rv_count++;
                rv_cyc      = cyc;
                last_result = result;
                last_sat    = sat;
            end
        end
    end

    // Drive one cycle of inputs, changed just after the falling edge
    task automatic applyStimulus(input bit s, input bit v, input longint p);
        @(negedge clk);
        #1;
        start      = s;
        prod_valid = v;
        prod       = SIZE_P'(p);
    endtask

    // One complete sum with optional idle gap before every term
    task automatic runSum(input string tag, input longint v[5], input bit gaps,
                          input longint exp_res, input bit exp_sat);
        int base;
        base = rv_count;
        applyStimulus(1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            if (gaps) begin
                applyStimulus(1'b0, 1'b0, longint'($urandom_range(0, 1000)));
            end
            applyStimulus(1'b0, 1'b1, v[i]);
        end
        repeat (4) applyStimulus(1'b0, 1'b0, 0);
        checkOutput({tag, " pulses"}, longint'(rv_count - base), 1);
        checkOutput({tag, " result"}, last_result, exp_res);
        checkOutput({tag, " sat"}, longint'(last_sat), longint'(exp_sat));
        checkOutput({tag, " latency"}, longint'(rv_cyc - m_last_accept_cyc), 2);
    endtask

    // Main sequence: reset, directed sums, then randomized traffic
    initial begin
        int               base;
        longint           p;
        logic signed [SIZE_P-1:0] rnd;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checking = 1'b1;
        #1;
        checkOutput("reset result", longint'(result), 0);
        checkOutput("reset result_valid", longint'(result_valid), 0);
        checkOutput("reset sat", longint'(sat), 0);
        checkOutput("reset busy", longint'(busy), 0);
        checkOutput("reset prod_ready", longint'(prod_ready), 0);
        rst_n = 1'b1;

        runSum("basic", '{1, 2, 3, 4, 5}, 1'b0, 15, 1'b0);
        runSum("pos clamp", '{MAXV, MAXV, MAXV, MAXV, MAXV}, 1'b0, MAXV, 1'b1);
        runSum("neg clamp", '{MINV, MINV, MINV, MINV, MINV}, 1'b0, MINV, 1'b1);
        runSum("recover", '{MAXV, 10, -20, 0, 0}, 1'b0, 2097131, 1'b1);
        runSum("gaps", '{1, 2, 3, 4, 5}, 1'b1, 15, 1'b0);

        // Reset part-way through a sum discards it
        base = rv_count;
        applyStimulus(1'b1, 1'b0, 0);
        repeat (3) applyStimulus(1'b0, 1'b1, 1);
        @(negedge clk);
        #2;
        rst_n      = 1'b0;
        start      = 1'b0;
        prod_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset mid-sum pulses", longint'(rv_count - base), 0);
        checkOutput("reset mid-sum busy", longint'(busy), 0);
        #1;
        rst_n = 1'b1;
        runSum("after reset", '{1, 1, 1, 1, 1}, 1'b0, 5, 1'b0);

        // Stray valid in IDLE, start in ACCUM and DONE are all ignored
        base = rv_count;
        repeat (3) applyStimulus(1'b0, 1'b1, 100);
        applyStimulus(1'b1, 1'b1, 100);
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b0, 1'b1, 3);
        applyStimulus(1'b0, 1'b1, 4);
        applyStimulus(1'b1, 1'b1, 5);
        applyStimulus(1'b1, 1'b1, 7);
        repeat (4) applyStimulus(1'b0, 1'b1, 9);
        checkOutput("ignore pulses", longint'(rv_count - base), 1);
        checkOutput("ignore result", last_result, 15);
        checkOutput("ignore sat", longint'(last_sat), 0);
        checkOutput("ignore busy", longint'(busy), 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                @(negedge clk);
                #2;
                rst_n = 1'b0;
                @(negedge clk);
                #2;
                rst_n = 1'b1;
            end
            case ($urandom_range(0, 3))
                0: p = longint'($urandom_range(0, 200)) - 100;
                1: p = MAXV - longint'($urandom_range(0, 50));
                2: p = MINV + longint'($urandom_range(0, 50));
                default: begin
                    rnd = SIZE_P'($urandom);
                    p   = rnd;
                end
            endcase
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, p);
        end
        repeat (4) applyStimulus(1'b0, 1'b0, 0);
        checking = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
